// File: rtl/piso_scanner.sv
// Scanner for an external 74LV165 parallel-in/serial-out chain: load, shift, commit snapshot.
// Optional build macro PISO_SCANNER_DEBOUNCE_EN: snapshot updates only after repeated identical scans.
module piso_scanner #(
  parameter int CHAIN_BITS     = 16,
  parameter int CLK_DIV        = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  scan_en,
  input  logic                  sr_data,
  output logic                  sr_clk,
  output logic                  sr_load_n,
  output logic [CHAIN_BITS-1:0] data,
  output logic                  valid,
  output logic                  change_irq,
  input  logic                  irq_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [7:0]            DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0]            BIT_LAST = 7'(CHAIN_BITS - 1);
  localparam logic [CHAIN_BITS-1:0] ALL_ONES = {CHAIN_BITS{1'b1}};

  if ((CHAIN_BITS < 2) || (CHAIN_BITS > 64) || (CLK_DIV < 1) || (CLK_DIV > 255) ||
      (DEBOUNCE_SCANS < 1) || (DEBOUNCE_SCANS > 15)) begin : g_bad_params
    $error("piso_scanner: parameter out of legal range");
  end

  state_t                  state_q, state_d;
  logic [7:0]              div_q, div_d;
  logic                    phase_q, phase_d;   // 0: sr_clk low half, 1: sr_clk high half
  logic [6:0]              bit_q, bit_d;
  logic [CHAIN_BITS-1:0]   raw_q, raw_d;
  logic [CHAIN_BITS-1:0]   data_q, data_d;
  logic                    irq_q, irq_d;
  logic                    valid_q, valid_d;
  logic                    sr_clk_q, sr_clk_d;
  logic                    sr_load_n_q, sr_load_n_d;
  logic                    phase_end_s;
  logic                    commit_s;

  // Next-state logic: phase/bit counters advance only on clken ticks; COMMIT is a single clk.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    raw_d       = raw_q;
    phase_end_s = clken && (div_q == DIV_LAST);
    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = LOAD;
          div_d   = 8'd0;
          phase_d = 1'b0;
          bit_d   = 7'd0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD, SHIFT: begin
        if (!clken) begin
          div_d = div_q;
        end else if (!phase_end_s) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d   = 8'd0;
          phase_d = ~phase_q;
          if (!phase_q) begin
            // last tick of the low half: Q7 is stable, capture before sr_clk rises
            if (state_q == SHIFT) begin
              raw_d = {raw_q[CHAIN_BITS-2:0], sr_data};
            end else begin
              raw_d = raw_q;
            end
          end else if (state_q == LOAD) begin
            state_d = SHIFT;
          end else if (bit_q == BIT_LAST) begin
            state_d = COMMIT;
          end else begin
            bit_d = bit_q + 7'd1;
          end
        end
      end
      COMMIT: begin
        state_d = scan_en ? LOAD : IDLE;
        div_d   = 8'd0;
        phase_d = 1'b0;
        bit_d   = 7'd0;
      end
      default: begin
        state_d = IDLE;
        div_d   = 8'd0;
        phase_d = 1'b0;
        bit_d   = 7'd0;
      end
    endcase
  end

  // Output decode from next state so the pins come straight from flops.
  always_comb begin
    sr_clk_d    = ((state_d == LOAD) || (state_d == SHIFT)) && phase_d;
    sr_load_n_d = (state_d != LOAD);
    valid_d     = (state_d == COMMIT);
  end

  // FSM, counters and raw shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      phase_q <= 1'b0;
      bit_q   <= 7'd0;
      raw_q   <= ALL_ONES;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      raw_q   <= raw_d;
    end
  end

  // Registered chain-control and strobe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_clk_q    <= 1'b0;
      sr_load_n_q <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      sr_clk_q    <= sr_clk_d;
      sr_load_n_q <= sr_load_n_d;
      valid_q     <= valid_d;
    end
  end

  assign commit_s = (state_q == COMMIT);

`ifdef PISO_SCANNER_DEBOUNCE_EN
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

  logic [CHAIN_BITS-1:0] prev_q, prev_d;
  logic [3:0]            stable_q, stable_d;

  // Snapshot update gated by a saturating run-length of identical raw scans.
  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    data_d   = data_q;
    if (commit_s) begin
      prev_d = raw_q;
      if (raw_q != prev_q) begin
        stable_d = 4'd1;
      end else if (stable_q >= DB_MAX) begin
        stable_d = DB_MAX;
      end else begin
        stable_d = stable_q + 4'd1;
      end
      if (stable_d == DB_MAX) begin
        data_d = raw_q;
      end else begin
        data_d = data_q;
      end
    end else begin
      prev_d = prev_q;
    end
  end

  // Debounce history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= ALL_ONES;
      stable_q <= 4'd0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
    end
  end
`else
  // Snapshot follows every completed scan.
  always_comb begin
    if (commit_s) begin
      data_d = raw_q;
    end else begin
      data_d = data_q;
    end
  end
`endif

  // Sticky change flag: a set in COMMIT beats a simultaneous acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (commit_s && (data_d != data_q)) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Snapshot and interrupt registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= ALL_ONES;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      irq_q  <= irq_d;
    end
  end

  assign sr_clk     = sr_clk_q;
  assign sr_load_n  = sr_load_n_q;
  assign data       = data_q;
  assign valid      = valid_q;
  assign change_irq = irq_q;

endmodule
